icache_refill_ctrl: RTL and testbench

//   Sequences instruction-cache line refills and whole-cache invalidation.

---
 rtl/icache_pkg.sv | 35 +++
 rtl/icache_set_walker.sv | 32 +++
 rtl/icache_refill_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and elaboration-time helpers for the icache refill controller.
// Field helpers work on a 64-bit view of the fetch address.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_BEAT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FLUSH  = 3'd4
  } refill_state_e;

  function automatic int calc_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_beat_w(input int line_bytes, input int bus_bytes);
    int beats;
    beats = line_bytes / bus_bytes;
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int line_bytes, input int index_w);
    return addr_w - $clog2(line_bytes) - index_w;
  endfunction

  // Extracts addr[lsb +: width]; callers truncate the result to the field width.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                             input int width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_set_walker.sv
// Walks every set index once, one per cycle, for whole-cache invalidation.
// i_start (re)loads set 0 even mid-walk; o_last marks the final set.
module icache_set_walker #(
  parameter int INDEX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  output logic [INDEX_W-1:0] o_idx,
  output logic               o_last
);

  logic [INDEX_W-1:0] r_idx;
  logic               r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_idx    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (o_last) r_active <= 1'b0;
      else        r_idx    <= r_idx + INDEX_W'(1);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = r_active && (r_idx == {INDEX_W{1'b1}});

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill sequencer: one burst read per miss, beat-by-beat data-array
// writes, then a tag commit; also runs whole-cache invalidation on flush.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter  int ADDR_W     = 64,
  parameter  int LINE_BYTES = 64,
  parameter  int BUS_BYTES  = 8,
  parameter  int INDEX_W    = 6,
  localparam int OFF_W      = calc_off_w(LINE_BYTES),
  localparam int BEATS      = LINE_BYTES / BUS_BYTES,
  localparam int BEAT_W     = calc_beat_w(LINE_BYTES, BUS_BYTES),
  localparam int TAG_W      = calc_tag_w(ADDR_W, LINE_BYTES, INDEX_W),
  localparam int DATA_W     = 8 * BUS_BYTES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_valid,
  input  logic [ADDR_W-1:0]  miss_addr,
  output logic               miss_ready,
  input  logic               kill,
  input  logic               flush,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic [7:0]         mem_req_len,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_data,
  input  logic               mem_rsp_last,
  input  logic               mem_rsp_err,
  output logic               arr_we,
  output logic [INDEX_W-1:0] arr_index,
  output logic [BEAT_W-1:0]  arr_beat,
  output logic [DATA_W-1:0]  arr_wdata,
  output logic               tag_we,
  output logic [INDEX_W-1:0] tag_index,
  output logic [TAG_W-1:0]   tag_value,
  output logic               tag_vld,
  output logic               busy,
  output logic               refill_done,
  output logic               refill_err
);

  refill_state_e      r_state;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic               r_last_seen;
  logic               r_err_stk;
  logic               r_kill_stk;
  logic               r_flush_pend;
  logic               r_mem_req_valid;
  logic [ADDR_W-1:0]  r_mem_req_addr;
  logic [7:0]         r_mem_req_len;
  logic               r_arr_we;
  logic [BEAT_W-1:0]  r_arr_beat;
  logic [DATA_W-1:0]  r_arr_wdata;
  logic               r_tag_we;
  logic               r_tag_vld;
  logic               r_refill_done;
  logic               r_refill_err;

  logic [INDEX_W-1:0] w_miss_index;
  logic [TAG_W-1:0]   w_miss_tag;
  logic [ADDR_W-1:0]  w_line_addr;
  logic               w_miss_fire;
  logic               w_beat_max;
  logic               w_proto_err;
  logic               w_kill_any;
  logic               w_walk_start;
  logic               w_walk_last;
  logic [INDEX_W-1:0] w_walk_idx;

  assign w_miss_index = INDEX_W'(addr_field(64'(miss_addr), OFF_W, INDEX_W));
  assign w_miss_tag   = TAG_W'(addr_field(64'(miss_addr), OFF_W + INDEX_W, TAG_W));
  assign w_line_addr  = {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_miss_fire  = miss_valid && miss_ready;
  assign w_beat_max   = (r_beat_cnt == BEAT_W'(BEATS - 1));
  // A beat count and the last flag that disagree means the burst length was violated.
  assign w_proto_err  = mem_rsp_last ^ w_beat_max;
  assign w_kill_any   = r_kill_stk || kill;

  // A walk starts whenever a pending flush can be serviced, including back-to-back re-walks.
  assign w_walk_start = r_flush_pend && ((r_state == ST_IDLE) || (r_state == ST_COMMIT) ||
                                         ((r_state == ST_FLUSH) && w_walk_last));

  icache_set_walker #(
    .INDEX_W (INDEX_W)
  ) u_walker (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_walk_start),
    .o_idx   (w_walk_idx),
    .o_last  (w_walk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_index         <= '0;
      r_tag           <= '0;
      r_beat_cnt      <= '0;
      r_last_seen     <= 1'b0;
      r_err_stk       <= 1'b0;
      r_kill_stk      <= 1'b0;
      r_flush_pend    <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_len   <= '0;
      r_arr_we        <= 1'b0;
      r_arr_beat      <= '0;
      r_arr_wdata     <= '0;
      r_tag_we        <= 1'b0;
      r_tag_vld       <= 1'b0;
      r_refill_done   <= 1'b0;
      r_refill_err    <= 1'b0;
    end else begin
      r_arr_we      <= 1'b0;
      r_tag_we      <= 1'b0;
      r_tag_vld     <= 1'b0;
      r_refill_done <= 1'b0;
      r_refill_err  <= 1'b0;

      if (flush)             r_flush_pend <= 1'b1;
      else if (w_walk_start) r_flush_pend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_flush_pend) begin
            r_state <= ST_FLUSH;
          end else if (w_miss_fire) begin
            r_index         <= w_miss_index;
            r_tag           <= w_miss_tag;
            r_mem_req_valid <= 1'b1;
            r_mem_req_addr  <= w_line_addr;
            r_mem_req_len   <= 8'(BEATS - 1);
            r_state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (kill) r_kill_stk <= 1'b1;
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_beat_cnt      <= '0;
            r_last_seen     <= 1'b0;
            r_state         <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (kill) r_kill_stk <= 1'b1;
          // The cycle after the last beat is the final array write; commit follows it.
          if (r_last_seen) begin
            r_tag_we      <= 1'b1;
            r_tag_vld     <= !r_err_stk && !w_kill_any;
            r_refill_done <= !r_err_stk && !w_kill_any;
            r_refill_err  <= r_err_stk;
            r_state       <= ST_COMMIT;
          end else if (mem_rsp_valid) begin
            r_arr_we    <= !(r_err_stk || mem_rsp_err);
            r_arr_beat  <= r_beat_cnt;
            r_arr_wdata <= mem_rsp_data;
            r_beat_cnt  <= w_beat_max ? '0 : r_beat_cnt + BEAT_W'(1);
            if (mem_rsp_err || w_proto_err) r_err_stk <= 1'b1;
            if (mem_rsp_last) r_last_seen <= 1'b1;
          end
        end
        ST_COMMIT: begin
          r_err_stk   <= 1'b0;
          r_kill_stk  <= 1'b0;
          r_last_seen <= 1'b0;
          r_state     <= r_flush_pend ? ST_FLUSH : ST_IDLE;
        end
        ST_FLUSH: begin
          if (w_walk_last && !r_flush_pend) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miss_ready    = (r_state == ST_IDLE) && !r_flush_pend && !flush;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_len   = r_mem_req_len;
  assign arr_we        = r_arr_we;
  assign arr_index     = r_index;
  assign arr_beat      = r_arr_beat;
  assign arr_wdata     = r_arr_wdata;
  assign tag_we        = r_tag_we || (r_state == ST_FLUSH);
  assign tag_index     = (r_state == ST_FLUSH) ? w_walk_idx : r_index;
  assign tag_value     = (r_state == ST_FLUSH) ? '0 : r_tag;
  assign tag_vld       = r_tag_vld;
  assign busy          = (r_state != ST_IDLE) || r_flush_pend;
  assign refill_done   = r_refill_done;
  assign refill_err    = r_refill_err;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: refill, bus error, kill, flush walk,
// early last with a stalled request, and reset mid-burst.
module tb_icache_refill_ctrl;

  localparam int ADDR_W  = 64;
  localparam int INDEX_W = 6;
  localparam int BEAT_W  = 3;
  localparam int TAG_W   = 52;
  localparam int DATA_W  = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               miss_valid;
  logic [ADDR_W-1:0]  miss_addr;
  logic               miss_ready;
  logic               kill;
  logic               flush;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic [7:0]         mem_req_len;
  logic               mem_rsp_valid;
  logic [DATA_W-1:0]  mem_rsp_data;
  logic               mem_rsp_last;
  logic               mem_rsp_err;
  logic               arr_we;
  logic [INDEX_W-1:0] arr_index;
  logic [BEAT_W-1:0]  arr_beat;
  logic [DATA_W-1:0]  arr_wdata;
  logic               tag_we;
  logic [INDEX_W-1:0] tag_index;
  logic [TAG_W-1:0]   tag_value;
  logic               tag_vld;
  logic               busy;
  logic               refill_done;
  logic               refill_err;

  icache_refill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .miss_valid    (miss_valid),
    .miss_addr     (miss_addr),
    .miss_ready    (miss_ready),
    .kill          (kill),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_len   (mem_req_len),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_last  (mem_rsp_last),
    .mem_rsp_err   (mem_rsp_err),
    .arr_we        (arr_we),
    .arr_index     (arr_index),
    .arr_beat      (arr_beat),
    .arr_wdata     (arr_wdata),
    .tag_we        (tag_we),
    .tag_index     (tag_index),
    .tag_value     (tag_value),
    .tag_vld       (tag_vld),
    .busy          (busy),
    .refill_done   (refill_done),
    .refill_err    (refill_err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          wr_cnt;
  int          wr_bad;
  logic [7:0]  wr_mask;
  logic [31:0] seed;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; logs data-array writes.
  task automatic step();
    @(posedge clk);
    #1;
    if (arr_we === 1'b1) begin
      wr_cnt++;
      wr_mask[arr_beat] = 1'b1;
      if (arr_wdata !== {seed, 29'd0, arr_beat}) wr_bad++;
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_miss_ready"}, miss_ready, 1);
    check({pfx, "_req_valid"}, mem_req_valid, 0);
    check({pfx, "_req_addr"}, mem_req_addr, 0);
    check({pfx, "_req_len"}, mem_req_len, 0);
    check({pfx, "_arr"}, {arr_we, arr_index, arr_beat}, 0);
    check({pfx, "_arr_wdata"}, arr_wdata, 0);
    check({pfx, "_tag"}, {tag_we, tag_vld, tag_index}, 0);
    check({pfx, "_tag_value"}, tag_value, 0);
    check({pfx, "_status"}, {busy, refill_done, refill_err}, 0);
  endtask

  // Issues a miss and serves the burst; returns in the commit cycle.
  task automatic refill(input string pfx, input logic [63:0] addr, input int req_delay,
                        input int nbeats, input int last_at, input int err_at,
                        input int kill_at, input int flush_at);
    wr_cnt  = 0;
    wr_bad  = 0;
    wr_mask = '0;
    check({pfx, "_miss_ready"}, miss_ready, 1);
    miss_valid = 1'b1;
    miss_addr  = addr;
    step();
    miss_valid = 1'b0;
    check({pfx, "_req_valid"}, mem_req_valid, 1);
    check({pfx, "_req_addr"}, mem_req_addr, addr & ~64'h3F);
    check({pfx, "_req_len"}, mem_req_len, 7);
    for (int d = 0; d < req_delay; d++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = '1;
      mem_rsp_last  = 1'b1;
      step();
      check({pfx, "_stall_req"}, {mem_req_valid, mem_req_len, mem_req_addr[31:0]},
            {1'b1, 8'd7, addr[31:6], 6'd0});
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check({pfx, "_req_drop"}, mem_req_valid, 0);
    check({pfx, "_no_early_wr"}, wr_cnt, 0);
    for (int b = 0; b < nbeats; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {seed, 32'(b)};
      mem_rsp_last  = (b == last_at);
      mem_rsp_err   = (b == err_at);
      kill          = (b == kill_at);
      flush         = (b == flush_at);
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    mem_rsp_err   = 1'b0;
    kill          = 1'b0;
    flush         = 1'b0;
    check({pfx, "_pre_commit"}, {tag_we, refill_done, refill_err}, 0);
    step();
  endtask

  initial begin
    int walk_bad;
    int n_walk;
    int snap;

    rst           = 1'b1;
    miss_valid    = 1'b0;
    miss_addr     = '0;
    kill          = 1'b0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_last  = 1'b0;
    mem_rsp_err   = 1'b0;
    seed          = 32'h0;
    wr_cnt        = 0;
    wr_bad        = 0;
    wr_mask       = '0;
    step();
    step();
    rst = 1'b0;
    check_reset("reset");

    // 1: clean refill, ideal memory; commit lands 11 cycles after accept
    seed = 32'hC0DE_0001;
    refill("t1", 64'h0000_1046, 0, 8, 7, -1, -1, -1);
    check("t1_commit", {tag_we, tag_vld, refill_done, refill_err}, 4'b1110);
    check("t1_tag_index", tag_index, 1);
    check("t1_tag_value", tag_value, 1);
    check("t1_wr_cnt", wr_cnt, 8);
    check("t1_wr_mask", wr_mask, 8'hFF);
    check("t1_wr_data", wr_bad, 0);
    check("t1_arr_index", arr_index, 1);
    step();
    check("t1_ready_back", {miss_ready, busy, tag_we, refill_done}, 4'b1000);

    // 2: bus error on beat 3, highest set index
    seed = 32'hC0DE_0002;
    refill("t2", 64'h0000_0000_ABCD_EFC2, 0, 8, 7, 3, -1, -1);
    check("t2_commit", {tag_we, tag_vld, refill_done, refill_err}, 4'b1001);
    check("t2_tag_index", tag_index, 63);
    check("t2_tag_value", tag_value, 64'hABCDE);
    check("t2_wr_cnt", wr_cnt, 3);
    check("t2_wr_mask", wr_mask, 8'h07);
    check("t2_wr_data", wr_bad, 0);
    step();
    check("t2_ready_back", {miss_ready, busy, refill_err}, 3'b100);

    // 3: kill during beat 5 -> full write, invalid commit, no pulses
    seed = 32'hC0DE_0003;
    refill("t3", 64'h0000_2000, 0, 8, 7, -1, 5, -1);
    check("t3_commit", {tag_we, tag_vld, refill_done, refill_err}, 4'b1000);
    check("t3_tag", {tag_index, tag_value[7:0]}, {6'd0, 8'd2});
    check("t3_wr_cnt", wr_cnt, 8);
    check("t3_wr_mask", wr_mask, 8'hFF);
    step();
    check("t3_ready_back", miss_ready, 1);

    // 4: flush mid-refill -> valid commit, then a full invalidation walk
    seed = 32'hC0DE_0004;
    refill("t4", 64'h0000_3080, 0, 8, 7, -1, -1, 2);
    check("t4_commit", {tag_we, tag_vld, refill_done, refill_err}, 4'b1110);
    check("t4_tag", {tag_index, tag_value[7:0]}, {6'd2, 8'd3});
    check("t4_commit_busy", {miss_ready, busy}, 2'b01);
    check("t4_wr_cnt", wr_cnt, 8);
    step();
    walk_bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (!(tag_we === 1'b1 && tag_vld === 1'b0 && tag_index === 6'(i) &&
            miss_ready === 1'b0 && busy === 1'b1)) walk_bad++;
      step();
    end
    check("t4_walk", walk_bad, 0);
    check("t4_walk_end", {tag_we, miss_ready, busy}, 3'b010);

    // 4b: flush from idle, re-flushed mid-walk -> two back-to-back walks
    flush = 1'b1;
    #1;
    check("t4b_ready_on_flush", miss_ready, 0);
    step();
    flush = 1'b0;
    check("t4b_pending", {busy, miss_ready, tag_we}, 3'b100);
    step();
    n_walk = 0;
    while (tag_we === 1'b1 && n_walk < 300) begin
      flush = (n_walk == 10);
      n_walk++;
      step();
      flush = 1'b0;
    end
    check("t4b_walk_len", n_walk, 128);
    check("t4b_idle", {busy, miss_ready}, 2'b01);

    // 5: request stalled 5 cycles with stray beats, then last early on beat 6
    seed = 32'hC0DE_0005;
    refill("t5", 64'h0000_4100, 5, 7, 6, -1, -1, -1);
    check("t5_commit", {tag_we, tag_vld, refill_done, refill_err}, 4'b1001);
    check("t5_tag_index", tag_index, 4);
    step();
    check("t5_ready_back", {miss_ready, busy}, 2'b10);

    // 6: reset during BEAT, then late beats must be ignored
    seed = 32'hC0DE_0006;
    wr_cnt = 0;
    wr_bad = 0;
    miss_valid = 1'b1;
    miss_addr  = 64'h0000_5000;
    step();
    miss_valid    = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {seed, 32'(b)};
      step();
    end
    mem_rsp_valid = 1'b0;
    check("t6_pre_reset_wr", wr_cnt, 3);
    check("t6_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("t6");
    snap = wr_cnt;
    mem_rsp_valid = 1'b1;
    mem_rsp_last  = 1'b1;
    step();
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    check("t6_late_ignored", wr_cnt - snap, 0);
    check("t6_idle", {busy, miss_ready, tag_we}, 3'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
